// File: rtl/alt_vipitc130_common_trigger_sync_multi.sv
// Multi-channel receive-side trigger synchroniser: per-channel CDC chain, event
// detect, saturating pending counters and handshake or self-paced pulse delivery.
module alt_vipitc130_common_trigger_sync_multi #(
  parameter int NUM_CHANNELS = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int COUNT_WIDTH  = 4,
  parameter int INPUT_MODE   = 0,
  parameter int PULSE_MODE   = 0
) (
  input  logic                                clock,
  input  logic                                rst_n,
  input  logic [NUM_CHANNELS-1:0]             trigger_in,
  input  logic [NUM_CHANNELS-1:0]             trigger_ack,
  input  logic                                overflow_clear,
  output logic [NUM_CHANNELS-1:0]             trigger_out,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] pending_count,
  output logic [NUM_CHANNELS-1:0]             overflow,
  output logic                                armed
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 1);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES);
  localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

  typedef enum logic {ST_WARM_UP, ST_ARMED} warm_state_t;

  warm_state_t state, state_next;
  logic [WARM_W-1:0] warm_cnt, warm_cnt_next;

  logic [NUM_CHANNELS-1:0] sync_stage [SYNC_STAGES];
  logic [NUM_CHANNELS-1:0] sync_q;
  logic [NUM_CHANNELS-1:0] sync_d;
  logic [NUM_CHANNELS-1:0] raw_event;
  logic [NUM_CHANNELS-1:0] armed_event;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_stage[s] <= '0;
      sync_d <= '0;
    end else begin
      sync_stage[0] <= trigger_in;
      for (int s = 1; s < SYNC_STAGES; s++) sync_stage[s] <= sync_stage[s-1];
      sync_d <= sync_q;
    end
  end

  assign sync_q    = sync_stage[SYNC_STAGES-1];
  assign raw_event = (INPUT_MODE == 0) ? (sync_q ^ sync_d) : (sync_q & ~sync_d);

  // Events are dropped until the chain has flushed the pre-reset input level.
  assign armed_event = raw_event & {NUM_CHANNELS{armed}};

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_WARM_UP;
      warm_cnt <= '0;
    end else begin
      state    <= state_next;
      warm_cnt <= warm_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    warm_cnt_next = warm_cnt;
    if (state == ST_WARM_UP) begin
      if (warm_cnt == WARM_LAST) state_next = ST_ARMED;
      else warm_cnt_next = warm_cnt + 1'b1;
    end
  end

  assign armed = (state == ST_ARMED);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic [COUNT_WIDTH-1:0] pending;
    logic pulse_q;
    logic ov_q;
    logic has_pending;
    logic consume;
    logic saturate;

    assign has_pending = (pending != '0);
    // Pulse mode paces itself: a consume only happens from a low output cycle.
    assign consume  = (PULSE_MODE != 0) ? (has_pending & ~pulse_q)
                                        : (has_pending & trigger_ack[c]);
    assign saturate = armed_event[c] & ~consume & (pending == COUNT_MAX);

    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        pending <= '0;
        pulse_q <= 1'b0;
        ov_q    <= 1'b0;
      end else begin
        if (armed_event[c] && !consume && !saturate) pending <= pending + 1'b1;
        else if (!armed_event[c] && consume) pending <= pending - 1'b1;
        pulse_q <= (PULSE_MODE != 0) & consume;
        if (saturate) ov_q <= 1'b1;
        else if (overflow_clear) ov_q <= 1'b0;
      end
    end

    assign trigger_out[c] = (PULSE_MODE != 0) ? pulse_q : has_pending;
    assign overflow[c]    = ov_q;
    assign pending_count[c*COUNT_WIDTH +: COUNT_WIDTH] = pending;
  end

endmodule

// File: tb/tb_alt_vipitc130_common_trigger_sync_multi.sv
// Directed self-checking bench: three instances cover toggle/handshake, small
// saturating counters, and level-input pulse delivery.
module tb_alt_vipitc130_common_trigger_sync_multi;

  logic clock = 1'b0;
  logic rst_n = 1'b1;
  always #5 clock = ~clock;

  logic [3:0]  a_in = '0, a_ack = '0, a_out, a_ov;
  logic        a_clr = 1'b0, a_armed;
  logic [15:0] a_cnt;

  logic [3:0]  b_in = '0, b_ack = '0, b_out, b_ov;
  logic        b_clr = 1'b0, b_armed;
  logic [7:0]  b_cnt;

  logic [3:0]  c_in = '0, c_ack = '0, c_out, c_ov;
  logic        c_clr = 1'b0, c_armed;
  logic [15:0] c_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  int pulses0 = 0, pulses3 = 0, pulses_other = 0, back_to_back = 0;
  logic prev0 = 1'b0;

  alt_vipitc130_common_trigger_sync_multi #(
    .NUM_CHANNELS(4), .SYNC_STAGES(2), .COUNT_WIDTH(4), .INPUT_MODE(0), .PULSE_MODE(0)
  ) u_a (
    .clock(clock), .rst_n(rst_n), .trigger_in(a_in), .trigger_ack(a_ack),
    .overflow_clear(a_clr), .trigger_out(a_out), .pending_count(a_cnt),
    .overflow(a_ov), .armed(a_armed)
  );

  alt_vipitc130_common_trigger_sync_multi #(
    .NUM_CHANNELS(4), .SYNC_STAGES(2), .COUNT_WIDTH(2), .INPUT_MODE(0), .PULSE_MODE(0)
  ) u_b (
    .clock(clock), .rst_n(rst_n), .trigger_in(b_in), .trigger_ack(b_ack),
    .overflow_clear(b_clr), .trigger_out(b_out), .pending_count(b_cnt),
    .overflow(b_ov), .armed(b_armed)
  );

  alt_vipitc130_common_trigger_sync_multi #(
    .NUM_CHANNELS(4), .SYNC_STAGES(2), .COUNT_WIDTH(4), .INPUT_MODE(1), .PULSE_MODE(1)
  ) u_c (
    .clock(clock), .rst_n(rst_n), .trigger_in(c_in), .trigger_ack(c_ack),
    .overflow_clear(c_clr), .trigger_out(c_out), .pending_count(c_cnt),
    .overflow(c_ov), .armed(c_armed)
  );

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    tests_run++;
    assert (observed === expected) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // One cycle of the pulse-mode instance, tallying pulses and scrambling acks.
  task automatic apply_stimulus(input int n);
    repeat (n) begin
      c_ack = 4'($urandom);
      tick(1);
      if (c_out[0]) begin
        pulses0++;
        if (prev0) back_to_back++;
      end
      prev0 = c_out[0];
      if (c_out[3]) pulses3++;
      pulses_other += int'(c_out[1]) + int'(c_out[2]);
    end
  endtask

  initial begin
    c_in = 4'hF;
    #1 rst_n = 1'b0;
    #2;
    check_output("reset_a_out", 32'(a_out), 32'h0);
    check_output("reset_a_cnt", 32'(a_cnt), 32'h0);
    check_output("reset_a_armed", 32'(a_armed), 32'h0);
    check_output("reset_b_ov", 32'(b_ov), 32'h0);
    check_output("reset_c_out", 32'(c_out), 32'h0);
    tick(2);
    rst_n = 1'b1;

    tick(2);
    check_output("warmup_armed_early", 32'({a_armed, b_armed, c_armed}), 32'h0);
    tick(1);
    check_output("warmup_armed", 32'({a_armed, b_armed, c_armed}), 32'h7);
    check_output("level_release_c_cnt", 32'(c_cnt), 32'h0);

    // Single toggle on channel 0 of the handshake instance
    a_in[0] = ~a_in[0];
    tick(2);
    check_output("t1_out_before", 32'(a_out[0]), 32'h0);
    tick(1);
    check_output("t1_out_rise", 32'(a_out[0]), 32'h1);
    check_output("t1_cnt", 32'(a_cnt[3:0]), 32'h1);
    a_ack[0] = 1'b1;
    tick(1);
    a_ack[0] = 1'b0;
    check_output("t1_cnt_after_ack", 32'(a_cnt[3:0]), 32'h0);
    check_output("t1_out_after_ack", 32'(a_out[0]), 32'h0);

    // Burst of five on channel 1, then drain
    for (int i = 0; i < 5; i++) begin
      a_in[1] = ~a_in[1];
      tick(4);
    end
    check_output("t2_cnt_burst", 32'(a_cnt[7:4]), 32'h5);
    check_output("t2_out", 32'(a_out[1]), 32'h1);
    a_ack[1] = 1'b1;
    tick(4);
    check_output("t2_cnt_partial", 32'(a_cnt[7:4]), 32'h1);
    tick(1);
    a_ack[1] = 1'b0;
    check_output("t2_cnt_drained", 32'(a_cnt[7:4]), 32'h0);
    check_output("t2_no_overflow", 32'(a_ov), 32'h0);
    check_output("t2_ch0_untouched", 32'(a_cnt[3:0]), 32'h0);

    // Saturation on a 2-bit counter, channel 2
    for (int i = 0; i < 4; i++) begin
      b_in[2] = ~b_in[2];
      tick(4);
    end
    check_output("t3_cnt_sat", 32'(b_cnt[5:4]), 32'h3);
    check_output("t3_ov_set", 32'(b_ov), 32'h4);
    b_in[2] = ~b_in[2];
    tick(2);
    b_clr = 1'b1;
    tick(1);
    b_clr = 1'b0;
    check_output("t3_set_beats_clear", 32'(b_ov[2]), 32'h1);
    check_output("t3_cnt_hold", 32'(b_cnt[5:4]), 32'h3);
    b_clr = 1'b1;
    tick(1);
    b_clr = 1'b0;
    check_output("t3_clear", 32'(b_ov), 32'h0);

    // Event and ack together at max, then ack with nothing pending
    b_in[2] = ~b_in[2];
    tick(2);
    b_ack[2] = 1'b1;
    tick(1);
    b_ack[2] = 1'b0;
    check_output("t4_cnt_max_ev_ack", 32'(b_cnt[5:4]), 32'h3);
    check_output("t4_no_overflow", 32'(b_ov), 32'h0);
    b_ack[3] = 1'b1;
    tick(1);
    b_ack[3] = 1'b0;
    check_output("t4_ack_at_zero", 32'(b_cnt[7:6]), 32'h0);
    check_output("t4_out_at_zero", 32'(b_out[3]), 32'h0);

    // Pulse delivery: three rising edges on channel 0 of the level/pulse instance
    for (int i = 0; i < 3; i++) begin
      c_in[0] = 1'b0;
      apply_stimulus(1);
      c_in[0] = 1'b1;
      apply_stimulus(1);
    end
    apply_stimulus(12);
    check_output("t5_pulse_count", 32'(pulses0), 32'd3);
    check_output("t5_back_to_back", 32'(back_to_back), 32'd0);
    check_output("t5_cnt_end", 32'(c_cnt[3:0]), 32'h0);

    // One low-then-high excursion on channel 3 gives exactly one event
    c_in[3] = 1'b0;
    apply_stimulus(2);
    c_in[3] = 1'b1;
    apply_stimulus(10);
    check_output("t6_ch3_pulses", 32'(pulses3), 32'd1);
    check_output("t6_other_pulses", 32'(pulses_other), 32'd0);
    check_output("t6_no_overflow", 32'(c_ov), 32'h0);

    // Reset in the middle of a burst
    for (int i = 0; i < 3; i++) begin
      a_in[1] = ~a_in[1];
      tick(2);
    end
    check_output("t6_cnt_pre_reset", 32'(a_cnt[7:4]), 32'h2);
    rst_n = 1'b0;
    #1;
    check_output("t6_reset_cnt", 32'(a_cnt), 32'h0);
    check_output("t6_reset_out", 32'(a_out), 32'h0);
    check_output("t6_reset_armed", 32'({a_armed, b_armed, c_armed}), 32'h0);
    check_output("t6_reset_b_cnt", 32'(b_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
